cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Synthesizable run controller for one or more CPU cores. It sits between the board or bench
//  clk/rst and the cores. It generates a programmable reset pulse and staggered per-core reset
//  release, then bounds each run by all-cores-halted or a cycle budget, reporting done/timeout
//  and the cycle count. Restartable via start without a global reset.
// PARAMETERS
//  RST_CYCLES  4    cycles cpu_rst held after start (>=1)
//  RUN_CYCLES  100  run budget in cycles; 0 = unlimited (no timeout)
//  N_CH        1    number of core reset/halt channels (>=1)
//  STAGGER     0    cycles between release of channel i and i+1
//  CNT_W       32   cycle_count width
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high global reset
//  start        in   1      begin a run (sampled in IDLE/DONE only)
//  halt_in      in   N_CH   per-core halt indication (level)
//  cpu_rst      out  N_CH   per-core reset, active high
//  running      out  1      run window active
//  done         out  1      run finished; held until next start
//  timeout      out  1      run ended on budget, valid while done=1
//  halted_mask  out  N_CH   sticky per-core halted flags
//  cycle_count  out  CNT_W  completed running cycles
// BEHAVIOUR
//  - Reset (rst=1 at edge): state IDLE. cpu_rst=all 1s, running=0, done=0, timeout=0,
//    halted_mask=0, cycle_count=0. rst overrides every state, including mid-run; the same values
//    appear on the next edge.
//  - FSM: IDLE -start-> RESET -RST_CYCLES elapsed-> RUN -halt-all|budget-> DONE -start-> RESET.
//  - start high in cycle T (state IDLE/DONE): from T+1, done=0, timeout=0, halted_mask=0,
//    cycle_count=0, and cpu_rst=all 1s.
//  - start is ignored in RESET and RUN.
//  - cpu_rst[i] is 1 through cycle T+RST_CYCLES+i*STAGGER and 0 from the following cycle.
//    With STAGGER=0, all channels release together.
//  - running=1 from cycle T+RST_CYCLES+1, the first cycle with cpu_rst[0]=0.
//  - cycle_count is 0 in the first running cycle and +1 at each edge while running.
//    It saturates at all 1s and holds its value in DONE.
//  - halt_in[i] is sampled only while running=1 and cpu_rst[i]=0. Sampled bits are ORed into
//    halted_mask, which is sticky. Halts of unreleased channels are ignored.
//  - Halt-all: if (halted_mask | sampled halt_in) == all 1s at an edge, then on the next cycle
//    state=DONE, done=1, timeout=0.
//  - Budget (RUN_CYCLES>0): at the edge where cycle_count==RUN_CYCLES-1 while running, go to
//    DONE with done=1, timeout=1. The run therefore lasts exactly RUN_CYCLES cycles.
//  - Halt-all and budget at the same edge: halt wins, timeout=0.
//  - In DONE: cpu_rst=all 1s, running=0, and done, timeout, halted_mask, cycle_count are held.
//  - start in the DONE cycle restarts the run at the next edge. Each done/start pair costs one
//    done cycle.
//  - All outputs are registered. There is no combinational path from inputs to outputs.
// STRUCTURE
//  - Package cpu_run_pkg: state encoding localparams (IDLE, RESET, RUN, DONE) and the
//    all-ones mask helper.
//  - One sub-module, sat_counter: CNT_W-bit up counter with sync clear, enable and saturation.
//    It is used for cycle_count.
//  - The phase counter (RESET/stagger timing) is kept inline. Its width is
//    clog2(RST_CYCLES+N_CH*STAGGER+1).
// TESTING
//  1. Defaults, rst 2 cycles, start 1 cycle at T, halt_in=0 -> cpu_rst falls at T+5;
//     done=1, timeout=1 after exactly 100 running cycles; cycle_count=99.
//  2. N_CH=3, STAGGER=2, RST_CYCLES=4 -> cpu_rst[0..2] fall at T+5, T+7, T+9;
//     halt_in[2] pulsed at T+6 is ignored.
//  3. N_CH=2: halt_in[0] at run cycle 10, halt_in[1] at run cycle 20 -> done=1, timeout=0,
//     halted_mask=2'b11, cycle_count=20.
//  4. Halt-all at the same edge as budget expiry (RUN_CYCLES=30) -> timeout=0.
//     RUN_CYCLES=0 with no halt -> running still 1 after 10000 cycles.
//  5. rst asserted mid-RUN -> next cycle IDLE, cpu_rst all 1s, all flags and counts 0;
//     start while in RUN -> no effect.
//  6. start held high continuously -> back-to-back runs, each with one done cycle.
//     CNT_W=4 with RUN_CYCLES=0 -> cycle_count saturates at 15.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run controller: FSM state encoding and mask helpers.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int MASK_MAX_W = 64;

  // Returns a vector with the low n bits set; callers cast it to their channel width.
  function automatic logic [MASK_MAX_W-1:0] ones_mask(input int unsigned n);
    logic [MASK_MAX_W-1:0] m;
    if (n >= MASK_MAX_W) m = '1;
    else                 m = (64'd1 << n) - 64'd1;
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up counter with synchronous reset and clear, count enable, and saturation at all ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for CPU cores: programmable reset pulse, staggered per-core release,
// and a run window bounded by all-cores-halted or a cycle budget.
//
//   state    | meaning
//   ST_IDLE  | after global reset, cores held, waiting for start
//   ST_RESET | cores held for RST_CYCLES after start
//   ST_RUN   | run window, channels released by stagger, halts sampled
//   ST_DONE  | run ended, cores held, results frozen until next start
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int RUN_CYCLES = 100,
  parameter int N_CH       = 1,
  parameter int STAGGER    = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_CH-1:0]  halt_in,
  output logic [N_CH-1:0]  cpu_rst,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [N_CH-1:0]  halted_mask,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int PH_MAX = RST_CYCLES + (N_CH - 1) * STAGGER;
  localparam int PH_W   = $clog2(RST_CYCLES + N_CH * STAGGER + 1);
  localparam logic [N_CH-1:0] ALL_CH = N_CH'(ones_mask(N_CH));
  localparam logic [63:0] BUDGET_LAST = 64'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);

  state_t          state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [N_CH-1:0] cpu_rst_q, cpu_rst_d;
  logic [N_CH-1:0] halted_q, halted_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic [N_CH-1:0] sampled;
  logic            halt_all, budget_hit;
  logic            cnt_clr, cnt_en;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    halted_d   = halted_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    sampled    = '0;
    halt_all   = 1'b0;
    budget_hit = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RESET;
          ph_d      = '0;
          halted_d  = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      ST_RESET: begin
        ph_d = ph_q + 1'b1;
        if (int'(ph_d) >= RST_CYCLES) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Phase keeps advancing until the last channel is released.
        if (int'(ph_q) < PH_MAX) ph_d = ph_q + 1'b1;
        sampled    = halt_in & ~cpu_rst_q;
        halted_d   = halted_q | sampled;
        halt_all   = (halted_d == ALL_CH);
        budget_hit = (RUN_CYCLES > 0) && (64'(cnt) == BUDGET_LAST);
        if (halt_all) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b0;
        end else if (budget_hit) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Channel i leaves reset once the phase reaches RST_CYCLES + i*STAGGER.
    cpu_rst_d = ALL_CH;
    if (state_d == ST_RESET || state_d == ST_RUN) begin
      for (int i = 0; i < N_CH; i++) begin
        cpu_rst_d[i] = (int'(ph_d) < RST_CYCLES + i * STAGGER);
      end
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ph_q      <= '0;
      cpu_rst_q <= ALL_CH;
      halted_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cpu_rst_q <= cpu_rst_d;
      halted_q  <= halted_d;
      running_q <= running_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (cnt)
  );

  assign cpu_rst     = cpu_rst_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign halted_mask = halted_q;
  assign cycle_count = cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a randomized multi-channel instance checked every cycle
// against an offset-arithmetic model, plus directed default-parameter and saturation instances.
module tb_cpu_run_ctrl;

  localparam int AR = 4, AS = 2, AN = 3, ARUN = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit a_fin = 0, b_fin = 0, c_fin = 0;

  // Instance A: 3 channels, stagger 2, budget 30
  logic        a_rst, a_start;
  logic [2:0]  a_halt, a_cpu_rst, a_hm;
  logic        a_running, a_done, a_to;
  logic [15:0] a_cnt;

  cpu_run_ctrl #(.RST_CYCLES(AR), .RUN_CYCLES(ARUN), .N_CH(AN), .STAGGER(AS), .CNT_W(16)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .halt_in(a_halt), .cpu_rst(a_cpu_rst),
    .running(a_running), .done(a_done), .timeout(a_to), .halted_mask(a_hm), .cycle_count(a_cnt));

  // Instance B: default parameters
  logic        b_rst, b_start;
  logic [0:0]  b_halt, b_cpu_rst, b_hm;
  logic        b_running, b_done, b_to;
  logic [31:0] b_cnt;

  cpu_run_ctrl u_b (
    .clk(clk), .rst(b_rst), .start(b_start), .halt_in(b_halt), .cpu_rst(b_cpu_rst),
    .running(b_running), .done(b_done), .timeout(b_to), .halted_mask(b_hm), .cycle_count(b_cnt));

  // Instance C: unlimited budget, 4-bit count
  logic        c_rst, c_start;
  logic [1:0]  c_halt, c_cpu_rst, c_hm;
  logic        c_running, c_done, c_to;
  logic [3:0]  c_cnt;

  cpu_run_ctrl #(.RST_CYCLES(2), .RUN_CYCLES(0), .N_CH(2), .STAGGER(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(c_rst), .start(c_start), .halt_in(c_halt), .cpu_rst(c_cpu_rst),
    .running(c_running), .done(c_done), .timeout(c_to), .halted_mask(c_hm), .cycle_count(c_cnt));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model for instance A ----------------
  typedef struct packed {
    logic [2:0]  rst;
    logic        run;
    logic        dn;
    logic        to;
    logic [2:0]  hm;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    logic        to;
    logic [2:0]  hm;
    logic [15:0] cnt;
  } res_t;

  exp_t exp_q[$];
  res_t res_q[$];
  exp_t cur;
  int   hs[AN];       // halt pulse offset per channel (cycles after start), -1 = none
  int   c_end, e_off, to_m;

  function automatic int rel(input int i);
    return AR + i * AS + 1;       // first offset with channel i out of reset
  endfunction

  function automatic bit smp(input int i);
    return (hs[i] >= rel(i)) && (hs[i] <= e_off);
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e = '0;
    e.rst = 3'b111;
    return e;
  endfunction

  task automatic plan();
    bit all_ok;
    int mx;
    all_ok = 1;
    mx = 0;
    for (int i = 0; i < AN; i++) begin
      if (hs[i] < rel(i)) all_ok = 0;
      else if (hs[i] > mx) mx = hs[i];
    end
    if (all_ok && (mx - (AR + 1) <= ARUN - 1)) begin
      c_end = mx - (AR + 1);
      to_m  = 0;
    end else begin
      c_end = ARUN - 1;
      to_m  = 1;
    end
    e_off = AR + 1 + c_end;
  endtask

  function automatic exp_t exp_at(input int k);
    exp_t e;
    int rc;
    for (int i = 0; i < AN; i++) begin
      e.rst[i] = (k > e_off) || (k <= AR + i * AS);
      e.hm[i]  = smp(i) && (hs[i] < k);
    end
    e.run = (k >= AR + 1) && (k <= e_off);
    e.dn  = (k == e_off + 1);
    e.to  = e.dn && (to_m != 0);
    rc    = k - AR - 1;
    if (rc < 0) rc = 0;
    if (rc > c_end) rc = c_end;
    e.cnt = 16'(rc);
    return e;
  endfunction

  task automatic push_a(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_hs(input int h0, input int h1, input int h2);
    hs[0] = h0; hs[1] = h1; hs[2] = h2;
  endtask

  task automatic rand_hs();
    for (int i = 0; i < AN; i++) begin
      if ($urandom_range(0, 4) == 0) hs[i] = -1;
      else hs[i] = int'($urandom_range(rel(i) - 3, rel(i) + ARUN + 2));
    end
  endtask

  task automatic run_a(input int gap);
    res_t r;
    for (int g = 0; g < gap; g++) begin
      a_start = 0;
      a_halt  = 3'($urandom);
      push_a(cur);
    end
    a_start = 1;
    a_halt  = 3'($urandom);
    push_a(cur);
    plan();
    r.to  = (to_m != 0);
    r.cnt = 16'(c_end);
    for (int i = 0; i < AN; i++) r.hm[i] = smp(i);
    res_q.push_back(r);
    for (int k = 1; k <= e_off; k++) begin
      a_start = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < AN; i++) a_halt[i] = (hs[i] == k);
      push_a(exp_at(k));
    end
    cur     = exp_at(e_off + 1);
    a_start = 0;
    a_halt  = 0;
  endtask

  initial begin
    a_rst = 1; a_start = 0; a_halt = 0;
    repeat (2) @(posedge clk);
    #1 a_rst = 0;
    cur = reset_exp();
    push_a(cur);
    push_a(cur);
    set_hs(-1, -1, 6);   run_a(0);
    set_hs(15, 25, 30);  run_a(2);
    set_hs(34, 34, 34);  run_a(0);
    set_hs(35, 35, 35);  run_a(1);
    set_hs(8, 9, 9);     run_a(0);
    for (int r = 0; r < 20; r++) begin
      rand_hs();
      run_a(int'($urandom_range(0, 3)));
    end
    // global reset in the middle of a run
    set_hs(-1, -1, -1);
    a_start = 1;
    push_a(cur);
    plan();
    for (int k = 1; k <= 12; k++) begin
      a_start = (k == 7);
      push_a(exp_at(k));
    end
    a_start = 0;
    a_rst   = 1;
    push_a(exp_at(13));
    a_rst = 0;
    cur = reset_exp();
    push_a(cur);
    push_a(cur);
    set_hs(20, 20, 20);  run_a(0);
    push_a(cur);
    push_a(cur);
    a_fin = 1;
  end

  // Monitor: per-cycle compare plus one result compare per completed run.
  exp_t m_e;
  res_t m_r;
  bit   a_done_prev = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      chk("a_cpu_rst", 64'(a_cpu_rst), 64'(m_e.rst));
      chk("a_running", 64'(a_running), 64'(m_e.run));
      chk("a_done",    64'(a_done),    64'(m_e.dn));
      chk("a_timeout", 64'(a_to),      64'(m_e.to));
      chk("a_halted",  64'(a_hm),      64'(m_e.hm));
      chk("a_count",   64'(a_cnt),     64'(m_e.cnt));
    end
    if (a_done === 1'b1 && !a_done_prev) begin
      if (res_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_result: done rose with no run outstanding (t=%0t)", $time);
      end else begin
        m_r = res_q.pop_front();
        chk("a_res_timeout", 64'(a_to),  64'(m_r.to));
        chk("a_res_halted",  64'(a_hm),  64'(m_r.hm));
        chk("a_res_count",   64'(a_cnt), 64'(m_r.cnt));
      end
    end
    a_done_prev = (a_done === 1'b1);
  end

  // ---------------- instance B: default parameters ----------------
  initial begin
    b_rst = 1; b_start = 0; b_halt = 0;
    repeat (2) @(posedge clk);
    #1 b_rst = 0;
    chk("b_reset_cpu_rst", 64'(b_cpu_rst), 64'd1);
    chk("b_reset_running", 64'(b_running), 64'd0);
    chk("b_reset_done",    64'(b_done),    64'd0);
    chk("b_reset_count",   64'(b_cnt),     64'd0);
    @(posedge clk); #1;
    b_start = 1;
    @(posedge clk); #1;
    b_start = 0;
    for (int k = 1; k <= 4; k++) begin
      chk("b_rst_held", 64'(b_cpu_rst), 64'd1);
      chk("b_not_run",  64'(b_running), 64'd0);
      @(posedge clk); #1;
    end
    chk("b_release_cpu_rst", 64'(b_cpu_rst), 64'd0);
    chk("b_release_running", 64'(b_running), 64'd1);
    chk("b_release_count",   64'(b_cnt),     64'd0);
    for (int k = 5; k < 104; k++) begin
      b_start = (k == 50);
      @(posedge clk); #1;
    end
    b_start = 0;
    chk("b_last_running", 64'(b_running), 64'd1);
    chk("b_last_count",   64'(b_cnt),     64'd99);
    chk("b_last_done",    64'(b_done),    64'd0);
    @(posedge clk); #1;
    chk("b_end_done",    64'(b_done),    64'd1);
    chk("b_end_timeout", 64'(b_to),      64'd1);
    chk("b_end_count",   64'(b_cnt),     64'd99);
    chk("b_end_running", 64'(b_running), 64'd0);
    chk("b_end_cpu_rst", 64'(b_cpu_rst), 64'd1);
    @(posedge clk); #1;
    chk("b_hold_done",  64'(b_done), 64'd1);
    chk("b_hold_count", 64'(b_cnt),  64'd99);
    b_fin = 1;
  end

  // ---------------- instance C: unlimited budget, saturation ----------------
  initial begin
    c_rst = 1; c_start = 0; c_halt = 0;
    repeat (2) @(posedge clk);
    #1 c_rst = 0;
    c_start = 1;
    c_halt  = 2'b01;
    @(posedge clk); #1;
    c_start = 0;
    repeat (10000) @(posedge clk);
    #1;
    chk("c_long_running", 64'(c_running), 64'd1);
    chk("c_sat_count",    64'(c_cnt),     64'd15);
    chk("c_long_halted",  64'(c_hm),      64'd1);
    chk("c_long_done",    64'(c_done),    64'd0);
    chk("c_long_cpu_rst", 64'(c_cpu_rst), 64'd0);
    c_start = 1;
    @(posedge clk); #1;
    c_start = 0;
    chk("c_start_ignored", 64'(c_running), 64'd1);
    c_halt = 2'b10;
    @(posedge clk); #1;
    c_halt = 2'b00;
    chk("c_halt_done",    64'(c_done),    64'd1);
    chk("c_halt_timeout", 64'(c_to),      64'd0);
    chk("c_halt_mask",    64'(c_hm),      64'd3);
    chk("c_halt_count",   64'(c_cnt),     64'd15);
    chk("c_halt_running", 64'(c_running), 64'd0);
    chk("c_halt_cpu_rst", 64'(c_cpu_rst), 64'd3);
    @(posedge clk); #1;
    chk("c_done_hold", 64'(c_done), 64'd1);
    chk("c_mask_hold", 64'(c_hm),   64'd3);
    c_start = 1;
    @(posedge clk); #1;
    c_start = 0;
    chk("c_restart_done",    64'(c_done),    64'd0);
    chk("c_restart_count",   64'(c_cnt),     64'd0);
    chk("c_restart_mask",    64'(c_hm),      64'd0);
    chk("c_restart_cpu_rst", 64'(c_cpu_rst), 64'd3);
    @(posedge clk); #1;
    chk("c_t2_cpu_rst", 64'(c_cpu_rst), 64'd3);
    @(posedge clk); #1;
    chk("c_t3_cpu_rst", 64'(c_cpu_rst), 64'd2);
    chk("c_t3_running", 64'(c_running), 64'd1);
    @(posedge clk); #1;
    chk("c_t4_cpu_rst", 64'(c_cpu_rst), 64'd0);
    chk("c_t4_count",   64'(c_cnt),     64'd1);
    repeat (2) @(posedge clk);
    #1 c_rst = 1;
    @(posedge clk); #1;
    c_rst = 0;
    chk("c_midrst_cpu_rst", 64'(c_cpu_rst), 64'd3);
    chk("c_midrst_running", 64'(c_running), 64'd0);
    chk("c_midrst_done",    64'(c_done),    64'd0);
    chk("c_midrst_timeout", 64'(c_to),      64'd0);
    chk("c_midrst_count",   64'(c_cnt),     64'd0);
    chk("c_midrst_mask",    64'(c_hm),      64'd0);
    c_fin = 1;
  end

  // ---------------- completion ----------------
  initial begin
    for (int c = 0; c < 40000 && !(a_fin && b_fin && c_fin); c++) @(posedge clk);
    if (!(a_fin && b_fin && c_fin)) begin
      tests++;
      fails++;
      $display("FAIL watchdog: a=%0d b=%0d c=%0d finished, required all 1", a_fin, b_fin, c_fin);
    end
    repeat (2) @(posedge clk);
    chk("a_runs_outstanding", 64'(res_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
